// File: rtl/nf10_id_reader_pkg.sv
// Shared types and constants for the nf10 identifier reader.
package nf10_id_reader_pkg;

    localparam int unsigned IDX_W     = 4;
    localparam int unsigned ERR_CNT_W = 5;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BUF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Saturating increment for the error counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/nf10_id_reader_if.sv
// AXI4-Lite bus bundle between the identifier reader (master) and the interconnect.
interface nf10_id_reader_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/nf10_id_word_buf.sv
// 16x32 capture buffer: synchronous write, asynchronous read. Contents are not reset.
module nf10_id_word_buf
    import nf10_id_reader_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata_c
);

    logic [WORD_W-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/nf10_id_reader.sv
// AXI4-Lite read master fetching C_NUM_WORDS identifier words into a local buffer.
// Optional watchdog abort of stalled transactions: define NF10_ID_READER_TIMEOUT_EN.
module nf10_id_reader
    import nf10_id_reader_pkg::*;
#(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_ID_BASEADDR      = '0,
    parameter int unsigned                   C_NUM_WORDS        = 16,
    parameter int unsigned                   C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                 M_AXI_ACLK,
    input  logic                 M_AXI_ARESETN,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WORD_W-1:0]    rd_word,
`ifdef NF10_ID_READER_TIMEOUT_EN
    output logic                 timeout,
`endif
    nf10_id_reader_if.master     m_axi
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_WORDS - 1);

    if (C_M_AXI_DATA_WIDTH != WORD_W) begin : g_bad_data_width
        $error("nf10_id_reader: only 32-bit data is supported");
    end
    if (C_NUM_WORDS < 1 || C_NUM_WORDS > BUF_DEPTH) begin : g_bad_num_words
        $error("nf10_id_reader: C_NUM_WORDS must be 1..16");
    end
    if (C_TIMEOUT_CYCLES < 2 || C_TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("nf10_id_reader: C_TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] idx);
        return C_ID_BASEADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
    endfunction

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              cnt_q, cnt_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          valid_q, valid_d;
    logic                          error_q, error_d;
    logic [ERR_CNT_W-1:0]          err_cnt_q, err_cnt_d;
    logic                          buf_we_c;
    logic                          resp_err_c;
    logic [IDX_W-1:0]              cnt_inc_c;

`ifdef NF10_ID_READER_TIMEOUT_EN
    localparam int unsigned        WDOG_W    = 16;
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(C_TIMEOUT_CYCLES - 1);
    logic [WDOG_W-1:0]             wdog_q, wdog_d;
    logic                          timeout_q, timeout_d;
    logic                          wdog_trip_c;
`endif

    // Next-state and next-output logic; start is only honoured in IDLE outside the done cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        error_d    = error_q;
        err_cnt_d  = err_cnt_q;
        buf_we_c   = 1'b0;
        resp_err_c = (m_axi.rresp != RESP_OKAY);
        cnt_inc_c  = cnt_q + IDX_W'(1);
`ifdef NF10_ID_READER_TIMEOUT_EN
        timeout_d   = timeout_q;
        wdog_d      = (state_q == IDLE) ? wdog_q : wdog_q + WDOG_W'(1);
        wdog_trip_c = (state_q != IDLE) && (wdog_q >= WDOG_LAST);
`endif

        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d   = ADDR;
                    cnt_d     = '0;
                    araddr_d  = word_addr('0);
                    arvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    valid_d   = 1'b0;
                    error_d   = 1'b0;
                    err_cnt_d = '0;
`ifdef NF10_ID_READER_TIMEOUT_EN
                    timeout_d = 1'b0;
                    wdog_d    = '0;
`endif
                end
            end
            ADDR: begin
                if (m_axi.arready) begin
                    state_d   = DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            DATA: begin
                if (m_axi.rvalid) begin
                    buf_we_c = 1'b1;
                    rready_d = 1'b0;
                    if (resp_err_c) begin
                        error_d   = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = !(error_q || resp_err_c);
                    end else begin
                        state_d   = ADDR;
                        cnt_d     = cnt_inc_c;
                        araddr_d  = word_addr(cnt_inc_c);
                        arvalid_d = 1'b1;
`ifdef NF10_ID_READER_TIMEOUT_EN
                        wdog_d    = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef NF10_ID_READER_TIMEOUT_EN
        // A completing handshake wins over the watchdog in the same cycle.
        if (wdog_trip_c && (state_d == state_q)) begin
            state_d   = IDLE;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            valid_d   = 1'b0;
            error_d   = 1'b1;
            timeout_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
`ifdef NF10_ID_READER_TIMEOUT_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
`ifdef NF10_ID_READER_TIMEOUT_EN
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    nf10_id_word_buf u_word_buf (
        .clk     (M_AXI_ACLK),
        .we      (buf_we_c),
        .waddr   (cnt_q),
        .wdata   (m_axi.rdata),
        .raddr   (rd_idx),
        .rdata_c (rd_word)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign valid     = valid_q;
    assign error     = error_q;
    assign err_count = err_cnt_q;
`ifdef NF10_ID_READER_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
    assign m_axi.awaddr  = '0;
    assign m_axi.awvalid = 1'b0;
    assign m_axi.wdata   = '0;
    assign m_axi.wstrb   = '0;
    assign m_axi.wvalid  = 1'b0;
    assign m_axi.bready  = 1'b1;

endmodule
